// File: rtl/nios_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM with a
// one-stage read-response pipe and out-of-range access suppression.
module nios_onchip_mem_arbiter #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned BE_W   = 4,
   parameter int unsigned DEPTH  = 10000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic              oor_err
);

   logic last_grant_q, last_grant_d;
   logic rsp_vld_q, rsp_vld_d;
   logic rsp_own_q, rsp_own_d;
   logic rsp_oor_q, rsp_oor_d;
   logic oor_err_q, oor_err_d;

   logic              req0, req1, gnt0, gnt1, gnt, sel, sel_wr, in_range;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] rsp_data;

   // Grant, RAM drive and next-state; a tie goes to the master not granted last
   always_comb begin
      req0     = m0_read | m0_write;
      req1     = m1_read | m1_write;
      gnt0     = reset_n & req0 & (~req1 | last_grant_q);
      gnt1     = reset_n & req1 & (~req0 | ~last_grant_q);
      gnt      = gnt0 | gnt1;
      sel      = gnt1;
      sel_addr = sel ? m1_address : m0_address;
      sel_wr   = sel ? m1_write : m0_write;
      in_range = 32'(sel_addr) < DEPTH;

      mem_address    = sel_addr;
      mem_byteenable = sel ? m1_byteenable : m0_byteenable;
      mem_writedata  = sel ? m1_writedata : m0_writedata;
      mem_chipselect = gnt & in_range;
      mem_write      = gnt & in_range & sel_wr;
      mem_clken      = 1'b1;

      m0_waitrequest = ~reset_n | (req0 & ~gnt0);
      m1_waitrequest = ~reset_n | (req1 & ~gnt1);

      last_grant_d = gnt ? sel : last_grant_q;
      rsp_vld_d    = gnt & ~sel_wr;
      rsp_own_d    = sel;
      rsp_oor_d    = ~in_range;
      oor_err_d    = oor_err_q | (gnt & ~in_range);
   end

   // Route the pending response to its owner; out-of-range reads return zero
   always_comb begin
      rsp_data         = rsp_oor_q ? '0 : mem_readdata;
      m0_readdatavalid = reset_n & rsp_vld_q & ~rsp_own_q;
      m1_readdatavalid = reset_n & rsp_vld_q & rsp_own_q;
      m0_readdata      = m0_readdatavalid ? rsp_data : '0;
      m1_readdata      = m1_readdatavalid ? rsp_data : '0;
      oor_err          = oor_err_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant_q <= 1'b1;
         rsp_vld_q    <= 1'b0;
         rsp_own_q    <= 1'b0;
         rsp_oor_q    <= 1'b0;
         oor_err_q    <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         rsp_vld_q    <= rsp_vld_d;
         rsp_own_q    <= rsp_own_d;
         rsp_oor_q    <= rsp_oor_d;
         oor_err_q    <= oor_err_d;
      end
   end

endmodule

// File: tb/tb_nios_onchip_mem_arbiter.sv
// Bench for nios_onchip_mem_arbiter: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a transaction-level model.
module tb_nios_onchip_mem_arbiter;

   localparam int unsigned ADDR_W = 14;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned DEPTH  = 10000;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect, mem_write, mem_clken;
   logic [DATA_W-1:0] mem_writedata;
   logic [DATA_W-1:0] mem_readdata;
   logic              oor_err;

   int n_checks = 0;
   int n_fail   = 0;

   nios_onchip_mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata), .oor_err(oor_err)
   );

   always #5 clk = ~clk;

   // Environment RAM: byte-enabled write, registered read data
   logic [DATA_W-1:0] ram [16384];
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model state
   logic [31:0] mdl_mem [16384];
   int          mdl_last;       // index of the master granted most recently
   bit          mdl_pend;
   int          mdl_pend_own;
   logic [31:0] mdl_pend_data;
   bit          mdl_oor;
   bit          wait0_s, wait1_s;

   // Per-cycle compare against the model, sampled on the falling edge
   always @(negedge clk) begin
      wait0_s = m0_waitrequest;
      wait1_s = m1_waitrequest;
      if (!reset_n) begin
         chk("rst_wait0", 32'(m0_waitrequest), 32'd1);
         chk("rst_wait1", 32'(m1_waitrequest), 32'd1);
         chk("rst_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
         chk("rst_rd0", m0_readdata, 32'd0);
         chk("rst_rd1", m1_readdata, 32'd0);
         chk("rst_cs_we", 32'({mem_chipselect, mem_write}), 32'd0);
         mdl_last = 1;
         mdl_pend = 1'b0;
         mdl_oor  = 1'b0;
      end else begin
         bit r0, r1, wr, inr;
         int win;
         logic [13:0] a;
         logic [31:0] wd;
         logic [3:0]  be;
         chk("m_rdv0", 32'(m0_readdatavalid), 32'(mdl_pend && mdl_pend_own == 0));
         chk("m_rdv1", 32'(m1_readdatavalid), 32'(mdl_pend && mdl_pend_own == 1));
         chk("m_rd0", m0_readdata, (mdl_pend && mdl_pend_own == 0) ? mdl_pend_data : 32'd0);
         chk("m_rd1", m1_readdata, (mdl_pend && mdl_pend_own == 1) ? mdl_pend_data : 32'd0);
         chk("m_oor", 32'(oor_err), 32'(mdl_oor));
         r0 = m0_read | m0_write;
         r1 = m1_read | m1_write;
         if (r0 && r1) win = 1 - mdl_last;
         else if (r0)  win = 0;
         else if (r1)  win = 1;
         else          win = -1;
         chk("m_wait0", 32'(m0_waitrequest), 32'(r0 && win != 0));
         chk("m_wait1", 32'(m1_waitrequest), 32'(r1 && win != 1));
         mdl_pend = 1'b0;
         if (win < 0) begin
            chk("m_idle_cs", 32'(mem_chipselect), 32'd0);
         end else begin
            a   = (win == 1) ? m1_address : m0_address;
            wr  = (win == 1) ? m1_write : m0_write;
            wd  = (win == 1) ? m1_writedata : m0_writedata;
            be  = (win == 1) ? m1_byteenable : m0_byteenable;
            inr = int'(a) < int'(DEPTH);
            chk("m_cs", 32'(mem_chipselect), 32'(inr));
            chk("m_we", 32'(mem_write), 32'(inr && wr));
            if (inr) chk("m_addr", 32'(mem_address), 32'(a));
            if (inr && wr) begin
               chk("m_wdata", mem_writedata, wd);
               chk("m_be", 32'(mem_byteenable), 32'(be));
               for (int b = 0; b < 4; b++)
                  if (be[b]) mdl_mem[a][b*8 +: 8] = wd[b*8 +: 8];
            end
            if (!wr) begin
               mdl_pend      = 1'b1;
               mdl_pend_own  = win;
               mdl_pend_data = inr ? mdl_mem[a] : 32'd0;
            end
            if (!inr) mdl_oor = 1'b1;
            mdl_last = win;
         end
      end
   end

   task automatic idle();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic m0_req(input bit w, input int a, input logic [31:0] d, input logic [3:0] be);
      m0_read = !w; m0_write = w; m0_address = 14'(a); m0_writedata = d; m0_byteenable = be;
   endtask

   task automatic m1_req(input bit w, input int a, input logic [31:0] d, input logic [3:0] be);
      m1_read = !w; m1_write = w; m1_address = 14'(a); m1_writedata = d; m1_byteenable = be;
   endtask

   initial begin
      int g, prev_g, pulses;
      for (int i = 0; i < 16384; i++) begin ram[i] = 32'd0; mdl_mem[i] = 32'd0; end
      mem_readdata = 32'd0;
      mdl_last = 1; mdl_pend = 0; mdl_oor = 0;
      m0_address = '0; m1_address = '0; m0_byteenable = '0; m1_byteenable = '0;
      m0_writedata = '0; m1_writedata = '0;
      idle();
      reset_n = 0;
      tick(); tick();
      // Requests present during reset are stalled
      m0_req(0, 1, 0, 4'hF); m1_req(0, 2, 0, 4'hF);
      #2;
      chk("rst_w0", 32'(m0_waitrequest), 32'd1);
      chk("rst_w1", 32'(m1_waitrequest), 32'd1);
      chk("rst_oor", 32'(oor_err), 32'd0);

      // First cycle after reset: tie goes to m0, then m1
      tick(); reset_n = 1; #2;
      chk("tie_w0", 32'(m0_waitrequest), 32'd0);
      chk("tie_w1", 32'(m1_waitrequest), 32'd1);
      chk("tie_addr", 32'(mem_address), 32'd1);
      tick(); m0_read = 0; #2;
      chk("tie2_w1", 32'(m1_waitrequest), 32'd0);
      chk("tie2_addr", 32'(mem_address), 32'd2);
      chk("tie_rdv0", 32'(m0_readdatavalid), 32'd1);
      tick(); idle(); #2;
      chk("tie_rdv1", 32'(m1_readdatavalid), 32'd1);
      chk("tie_rdv0_off", 32'(m0_readdatavalid), 32'd0);

      // Single write then read-back
      tick(); m0_req(1, 5, 32'hDEADBEEF, 4'hF); #2;
      chk("wr_w0", 32'(m0_waitrequest), 32'd0);
      chk("wr_we", 32'(mem_write), 32'd1);
      chk("wr_addr", 32'(mem_address), 32'd5);
      tick(); m0_req(0, 5, 0, 4'hF); #2;
      chk("rd_we", 32'(mem_write), 32'd0);
      tick(); idle(); #2;
      chk("rd_rdv0", 32'(m0_readdatavalid), 32'd1);
      chk("rd_data", m0_readdata, 32'hDEADBEEF);
      chk("rd_rdv1", 32'(m1_readdatavalid), 32'd0);

      // m1 write so that m0 wins the next tie, then 8 cycles of contention
      tick(); m1_req(1, 100, 32'h0BADF00D, 4'hF);
      tick(); m0_req(0, 30, 0, 4'hF); m1_req(0, 31, 0, 4'hF);
      pulses = 0; prev_g = -1;
      for (int i = 0; i < 8; i++) begin
         #2;
         g = m0_waitrequest ? 1 : 0;
         chk("cont_grant", 32'(g), 32'(i % 2));
         chk("cont_one_wait", 32'(m0_waitrequest ^ m1_waitrequest), 32'd1);
         if (m0_readdatavalid || m1_readdatavalid) begin
            pulses++;
            chk("cont_route", 32'(m1_readdatavalid), 32'(prev_g));
         end
         prev_g = g;
         tick();
      end
      idle(); #2;
      if (m0_readdatavalid || m1_readdatavalid) begin
         pulses++;
         chk("cont_route", 32'(m1_readdatavalid), 32'(prev_g));
      end
      chk("cont_pulses", 32'(pulses), 32'd8);

      // Byte-enable merge
      tick(); m0_req(1, 9, 32'h11223344, 4'hF);
      tick(); m0_req(1, 9, 32'hAABBCCDD, 4'h2);
      tick(); m0_req(0, 9, 0, 4'hF);
      tick(); idle(); #2;
      chk("be_data", m0_readdata, 32'h1122CC44);

      // Out-of-range write and read
      tick(); m1_req(1, 10000, 32'h12345678, 4'hF); #2;
      chk("oor_wr_w1", 32'(m1_waitrequest), 32'd0);
      chk("oor_wr_cs", 32'(mem_chipselect), 32'd0);
      chk("oor_wr_we", 32'(mem_write), 32'd0);
      tick(); m1_req(0, 16383, 0, 4'hF); #2;
      chk("oor_rd_cs", 32'(mem_chipselect), 32'd0);
      chk("oor_flag", 32'(oor_err), 32'd1);
      tick(); idle(); #2;
      chk("oor_rdv1", 32'(m1_readdatavalid), 32'd1);
      chk("oor_rdata", m1_readdata, 32'd0);
      tick(); tick(); #2;
      chk("oor_sticky", 32'(oor_err), 32'd1);

      // Randomized traffic honouring the hold-while-stalled rule
      for (int c = 0; c < 3000; c++) begin
         tick();
         reset_n = ($urandom % 150) != 0;
         if (!wait0_s) begin
            m0_read = 1'($urandom); m0_write = ($urandom % 3) == 0;
            m0_address = ($urandom % 12 == 0) ? 14'(10000 + $urandom % 6384) : 14'($urandom % 64);
            m0_byteenable = 4'($urandom); m0_writedata = $urandom;
         end
         if (!wait1_s) begin
            m1_read = 1'($urandom); m1_write = ($urandom % 3) == 0;
            m1_address = ($urandom % 12 == 0) ? 14'(10000 + $urandom % 6384) : 14'($urandom % 64);
            m1_byteenable = 4'($urandom); m1_writedata = $urandom;
         end
      end

      // Reset in the cycle after an accepted read drops the response
      tick(); reset_n = 1; idle();
      tick(); m0_req(0, 5, 0, 4'hF); #2;
      chk("mr_w0", 32'(m0_waitrequest), 32'd0);
      tick(); reset_n = 0; m0_req(0, 5, 0, 4'hF); m1_req(0, 6, 0, 4'hF); #2;
      chk("mr_rdv0", 32'(m0_readdatavalid), 32'd0);
      chk("mr_w0_rst", 32'(m0_waitrequest), 32'd1);
      chk("mr_w1_rst", 32'(m1_waitrequest), 32'd1);
      tick(); reset_n = 1; idle(); #2;
      chk("mr_rdv0_after", 32'(m0_readdatavalid), 32'd0);
      chk("mr_oor_after", 32'(oor_err), 32'd0);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nios_onchip_mem_arbiter.md
Name: nios_onchip_mem_arbiter

Overview:
- Two-port round-robin arbiter in front of the single-port 32-bit on-chip RAM (14-bit word address, 4 byte enables, 1-cycle read latency, unregistered q).
- Lets two Avalon-MM masters share the RAM, for example the Nios data master and the SPI DMA/loader master.
- Issues at most one RAM access per clock.
- Routes each read response back to its originator with readdatavalid.
- Suppresses accesses to addresses at or beyond DEPTH.

Parameters:
- ADDR_W, 14, word address width.
- DATA_W, 32, data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- DEPTH, 10000, number of implemented words; an address >= DEPTH is out of range.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- mN_address  in  ADDR_W  master N word address (N = 0, 1).
- mN_byteenable  in  BE_W  master N byte enables.
- mN_read  in  1  master N read request.
- mN_write  in  1  master N write request.
- mN_writedata  in  DATA_W  master N write data.
- mN_waitrequest  out  1  master N stall; the request is accepted in a cycle where it is low.
- mN_readdata  out  DATA_W  master N read data.
- mN_readdatavalid  out  1  master N read data valid.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  BE_W  RAM byte enables.
- mem_chipselect  out  1  RAM chipselect.
- mem_write  out  1  RAM write enable.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable; tied to 1.
- mem_readdata  in  DATA_W  RAM q, valid one cycle after the read is issued.
- oor_err  out  1  sticky flag: an out-of-range access occurred.

Behaviour:
- Reset (reset_n sampled low at a clk edge):
  - last_grant <= 1, so m0 wins the first tie.
  - Response pipe cleared; oor_err <= 0.
  - While reset_n is low: mN_waitrequest = 1, mN_readdatavalid = 0, mN_readdata = 0, mem_chipselect = 0, mem_write = 0.
- Request: reqN = mN_read | mN_write. If both are set, the request is treated as a write.
- Grant (combinational, same cycle):
  - Only one master requesting: that master is granted.
  - Both requesting: grant goes to the master that is not last_grant.
  - Neither requesting: no grant; last_grant holds.
  - last_grant <= granted index on every granted cycle.
- mN_waitrequest = reqN & ~grantN. An ungranted master holds its request stable (Avalon rule); the arbiter does not latch its inputs.
- Granted, in-range access (address < DEPTH):
  - mem_address, mem_byteenable and mem_writedata are driven from the winner's inputs.
  - mem_chipselect = 1; mem_write = 1 only for a write.
- Granted, out-of-range access:
  - Accepted (waitrequest low) but not forwarded: mem_chipselect = 0, mem_write = 0.
  - oor_err <= 1, held until reset.
- Read response pipe, one stage:
  - On an accepted read: rsp_vld <= 1, rsp_own <= N, rsp_oor <= out-of-range bit. Otherwise rsp_vld <= 0.
  - In the next cycle, if rsp_vld: m[rsp_own]_readdatavalid = 1 and m[rsp_own]_readdata = rsp_oor ? 0 : mem_readdata.
  - The other master's readdatavalid is 0 and its readdata is 0.
- Timing:
  - Read latency: accept at cycle T, data at T+1.
  - Writes complete on accept, with no response.
  - Throughput: one access per cycle, back-to-back reads pipelined.
  - A response from T and a new accept at T+1 coexist.
- Sustained contention from both masters: grants strictly alternate 0,1,0,1. A master waits at most 1 cycle.
- Reset asserted with a read response pending: the response is dropped and readdatavalid is not asserted after reset.
- Read-during-write to the same address by the two masters in consecutive cycles: the write is issued first (grant order), so the read returns the new data. No same-cycle hazard exists, since only one access per cycle reaches the RAM.

Test Plan:
- Reset then single write: m0 writes 0xDEADBEEF to addr 5, be=0xF.
  - Required: m0_waitrequest = 0 in the same cycle; mem_write = 1, mem_address = 5.
  - Then m0 reads addr 5: m0_readdatavalid = 1 exactly 1 cycle later with 0xDEADBEEF; m1_readdatavalid stays 0.
- Simultaneous reads, first cycle after reset: m0 reads addr 1, m1 reads addr 2.
  - Required: m0 is granted first (m1_waitrequest = 1), then m1 the next cycle.
  - Data returns to the correct master in consecutive cycles.
- Sustained contention for 8 cycles: both masters issue back-to-back reads.
  - Required: grant sequence 0,1,0,1,0,1,0,1; no master waits more than 1 cycle; 8 readdatavalid pulses, correctly routed.
- Byte enable: write 0x11223344 to addr 9, then write 0xAABBCCDD with be=0x2, then read addr 9.
  - Required: read returns 0x1122CC44.
- Out-of-range: m1 writes addr 10000, then reads addr 16383.
  - Required: mem_chipselect = 0 for both.
  - Read returns 0x00000000 with readdatavalid asserted.
  - oor_err = 1 and stays 1 until reset_n is low.
- Reset mid-read: assert reset_n = 0 in the cycle after an accepted m0 read.
  - Required: no m0_readdatavalid; both waitrequests = 1 while in reset; oor_err = 0 after reset.
